// File: rtl/cordic_seq.sv
// Sequencer that feeds one operand set to an iterative CORDIC, waits for the last
// iteration, captures the result and hands it downstream. Optional watchdog: CORDIC_SEQ_WATCHDOG_EN.
module cordic_seq #(
    parameter int WIDTH = 15,
    parameter int ITERS = 16,
    parameter int TMO   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_m,
    input  logic             in_div,
    input  logic [WIDTH:0]   in_x,
    input  logic [WIDTH:0]   in_y,
    input  logic [WIDTH:0]   in_z,
    output logic             cd_reset,
    output logic             cd_m,
    output logic             cd_div,
    output logic [WIDTH:0]   cd_xo,
    output logic [WIDTH:0]   cd_yo,
    output logic [WIDTH:0]   cd_zo,
    input  logic [WIDTH:0]   cd_xout,
    input  logic [WIDTH:0]   cd_yout,
    input  logic [WIDTH:0]   cd_zout,
    input  logic [3:0]       cd_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_x,
    output logic [WIDTH:0]   out_y,
    output logic [WIDTH:0]   out_z,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] LAST_I = 4'(ITERS - 1);

    state_t         state_q, state_d;
    logic           cd_reset_q, cd_reset_d;
    logic           cd_m_q, cd_m_d;
    logic           cd_div_q, cd_div_d;
    logic [WIDTH:0] cd_xo_q, cd_xo_d;
    logic [WIDTH:0] cd_yo_q, cd_yo_d;
    logic [WIDTH:0] cd_zo_q, cd_zo_d;
    logic           out_valid_q, out_valid_d;
    logic [WIDTH:0] out_x_q, out_x_d;
    logic [WIDTH:0] out_y_q, out_y_d;
    logic [WIDTH:0] out_z_q, out_z_d;
    logic           accept_s;

`ifdef CORDIC_SEQ_WATCHDOG_EN
    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // in_ready must follow out_ready in DONE so a new job can slip in without a bubble
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s = in_valid && in_ready;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cd_m_d    = cd_m_q;
        cd_div_d  = cd_div_q;
        cd_xo_d   = cd_xo_q;
        cd_yo_d   = cd_yo_q;
        cd_zo_d   = cd_zo_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_z_d   = out_z_q;
`ifdef CORDIC_SEQ_WATCHDOG_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = LOAD;
                else          state_d = IDLE;
            end
            LOAD: begin
                state_d = RUN;
`ifdef CORDIC_SEQ_WATCHDOG_EN
                cnt_d   = '0;
`endif
            end
            RUN: begin
                if (cd_i == LAST_I) begin
                    state_d = CAPT;
`ifdef CORDIC_SEQ_WATCHDOG_EN
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = RUN;
`else
                end else begin
                    state_d = RUN;
`endif
                end
            end
            CAPT: begin
                out_x_d = cd_xout;
                out_y_d = cd_yout;
                out_z_d = cd_zout;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready && in_valid) state_d = LOAD;
                else if (out_ready)        state_d = IDLE;
                else                       state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (accept_s) begin
            cd_m_d   = in_m;
            cd_div_d = in_div;
            cd_xo_d  = in_x;
            cd_yo_d  = in_y;
            cd_zo_d  = in_z;
        end else begin
            cd_m_d   = cd_m_q;
        end
        out_valid_d = (state_d == DONE);
        cd_reset_d  = (state_d == LOAD);
    end

    // State and output registers; cd_reset is held high through reset to keep the CORDIC parked
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cd_reset_q  <= 1'b1;
            cd_m_q      <= 1'b0;
            cd_div_q    <= 1'b0;
            cd_xo_q     <= '0;
            cd_yo_q     <= '0;
            cd_zo_q     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
`ifdef CORDIC_SEQ_WATCHDOG_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cd_reset_q  <= cd_reset_d;
            cd_m_q      <= cd_m_d;
            cd_div_q    <= cd_div_d;
            cd_xo_q     <= cd_xo_d;
            cd_yo_q     <= cd_yo_d;
            cd_zo_q     <= cd_zo_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
`ifdef CORDIC_SEQ_WATCHDOG_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cd_reset  = cd_reset_q;
    assign cd_m      = cd_m_q;
    assign cd_div    = cd_div_q;
    assign cd_xo     = cd_xo_q;
    assign cd_yo     = cd_yo_q;
    assign cd_zo     = cd_zo_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Directed bench for cordic_seq with a toy CORDIC model: x+i, y+2i, z-i, i saturating at 15.
module tb_cordic_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_m, in_div;
    logic [15:0] in_x, in_y, in_z;
    logic        cd_reset, cd_m, cd_div;
    logic [15:0] cd_xo, cd_yo, cd_zo, cd_xout, cd_yout, cd_zout;
    logic [3:0]  cd_i;
    logic        out_valid, out_ready;
    logic [15:0] out_x, out_y, out_z;
    logic        err;

    logic [3:0]  mi;
    logic        stuck;
    int          n_vec = 0;
    int          n_err = 0;

    cordic_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_m(in_m), .in_div(in_div), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .cd_reset(cd_reset), .cd_m(cd_m), .cd_div(cd_div),
        .cd_xo(cd_xo), .cd_yo(cd_yo), .cd_zo(cd_zo),
        .cd_xout(cd_xout), .cd_yout(cd_yout), .cd_zout(cd_zout), .cd_i(cd_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .err(err)
    );

    always #5 clk = ~clk;

    // CORDIC stand-in: restarts on cd_reset, counts to 15 and holds, or sticks at 3
    always @(posedge clk) begin
        if (cd_reset)     mi <= 4'd0;
        else if (stuck)   mi <= 4'd3;
        else if (mi != 4'd15) mi <= mi + 4'd1;
    end
    assign cd_i    = mi;
    assign cd_xout = cd_xo + {12'h000, mi};
    assign cd_yout = cd_yo + {11'h000, mi, 1'b0};
    assign cd_zout = cd_zo - {12'h000, mi};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one operand set; returns just after the accepting edge (edge 0)
    task automatic accept_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        in_valid = 1'b1; in_x = x; in_y = y; in_z = z; in_m = 1'b1; in_div = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges from the current cycle until out_valid, bounded
    task automatic run_to_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 60);
    endtask

    int lat;
    bit seen;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_m = 1'b0; in_div = 1'b0;
        in_x = 16'h0000; in_y = 16'h0000; in_z = 16'h0000;
        out_ready = 1'b0; stuck = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cd_reset", {31'd0, cd_reset}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cd_xo", {16'd0, cd_xo}, 32'h0);
        check("rst_out_x", {16'd0, out_x}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single job with backpressure; in_valid noise during RUN must be ignored
        accept_job(16'h4000, 16'h0000, 16'h1000);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            check($sformatf("j1_cd_reset_c%0d", c), {31'd0, cd_reset}, {31'd0, c == 1});
            check($sformatf("j1_out_valid_c%0d", c), {31'd0, out_valid}, {31'd0, c == 19});
            if (c == 1) check("j1_cd_xo", {16'd0, cd_xo}, 32'h4000);
            if (c == 3) begin in_valid = 1'b1; in_x = 16'h7777; end
            if (c == 6) in_valid = 1'b0;
            if (c == 7) check("j1_ignore_in", {16'd0, cd_xo}, 32'h4000);
        end
        check("j1_out_x", {16'd0, out_x}, 32'h400F);
        check("j1_out_y", {16'd0, out_y}, 32'h001E);
        check("j1_out_z", {16'd0, out_z}, 32'h0FF1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_x", {16'd0, out_x}, 32'h400F);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_idle", {31'd0, in_ready}, 32'd1);

        // back-to-back: second job offered while the first result is in DONE
        accept_job(16'h0100, 16'h0200, 16'h0300);
        for (int c = 1; c <= 18; c++) @(negedge clk);
        in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h0010; in_z = 16'h0020;
        @(negedge clk);
        check("b2b_valid1", {31'd0, out_valid}, 32'd1);
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        check("b2b_out_x1", {16'd0, out_x}, 32'h010F);
        check("b2b_out_y1", {16'd0, out_y}, 32'h021E);
        check("b2b_out_z1", {16'd0, out_z}, 32'h02F1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_load_cd_xo", {16'd0, cd_xo}, 32'h1234);
        check("b2b_load_cd_reset", {31'd0, cd_reset}, 32'd1);
        check("b2b_load_valid", {31'd0, out_valid}, 32'd0);
        run_to_valid(lat);
        check("b2b_latency", lat + 1, 32'd19);
        check("b2b_out_x2", {16'd0, out_x}, 32'h1243);
        check("b2b_out_y2", {16'd0, out_y}, 32'h002E);
        check("b2b_out_z2", {16'd0, out_z}, 32'h0011);
        @(negedge clk);
        check("b2b_idle", {31'd0, in_ready}, 32'd1);

        // reset in cycle 8 of a job aborts it
        accept_job(16'h0555, 16'h0000, 16'h0000);
        for (int c = 1; c <= 8; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_cd_xo", {16'd0, cd_xo}, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_valid", {31'd0, seen}, 32'd0);
        accept_job(16'h2000, 16'h0001, 16'h0002);
        run_to_valid(lat);
        check("mrst_next_latency", lat, 32'd19);
        check("mrst_next_out_x", {16'd0, out_x}, 32'h200F);
        check("mrst_next_out_y", {16'd0, out_y}, 32'h001F);
        check("mrst_next_out_z", {16'd0, out_z}, 32'hFFF3);
        @(negedge clk);

        // CORDIC never reaches its last iteration
        stuck = 1'b1;
        accept_job(16'h0001, 16'h0002, 16'h0003);
        for (int c = 1; c <= 25; c++) @(negedge clk);
        check("wd_c25_err", {31'd0, err}, 32'd0);
        check("wd_c25_busy", {31'd0, in_ready}, 32'd0);
`ifdef CORDIC_SEQ_WATCHDOG_EN
        @(negedge clk);
        check("wd_err_set", {31'd0, err}, 32'd1);
        check("wd_idle", {31'd0, in_ready}, 32'd1);
        check("wd_no_valid", {31'd0, out_valid}, 32'd0);
        repeat (5) @(negedge clk);
        check("wd_err_sticky", {31'd0, err}, 32'd1);
`else
        repeat (15) @(negedge clk);
        check("nowd_err", {31'd0, err}, 32'd0);
        check("nowd_still_run", {31'd0, in_ready}, 32'd0);
        check("nowd_no_valid", {31'd0, out_valid}, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check("final_err_clear", {31'd0, err}, 32'd0);
        check("final_in_ready", {31'd0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
